// File: rtl/mips_mc_core.sv
// mips_mc_core: multi-cycle MIPS subset core with a single unified memory port.
//
// Supported instructions: addu, subu, ori, lui, lw, sw, beq, j (and jal when the
// MIPS_MC_JAL_EN macro is defined; otherwise jal is an illegal opcode).
// Each instruction walks FETCH -> DECODE -> EXEC [-> MEM] [-> WB]. The core stops
// in HALT on an illegal opcode/funct or when a memory transaction waits too long;
// only reset leaves HALT.
//
// Ports:
//   clk        single clock, rising edge
//   reset      asynchronous active-high reset
//   mem_req    memory transaction request (FETCH or MEM state)
//   mem_we     1 = store, 0 = load/fetch
//   mem_addr   word address (byte address bits [MEM_AW+1:2])
//   mem_wdata  store data
//   mem_rdata  load/fetch data, sampled when mem_req & mem_ready
//   mem_ready  completes the current transaction
//   halted     core stopped (illegal instruction or memory timeout)
//   retire     one-cycle pulse per completed instruction
//   pc_out     PC of the instruction in flight
//
// Configuration macro: MIPS_MC_JAL_EN (enables jal).
module mips_mc_core #(
  parameter logic [31:0] RESET_PC     = 32'h0000_3000,
  parameter int unsigned MEM_AW       = 10,
  parameter int unsigned MEM_WAIT_MAX = 255
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              halted,
  output logic              retire,
  output logic [31:0]       pc_out
);

  // Wait counter holds 0 .. MEM_WAIT_MAX-1; the last value times out.
  localparam int unsigned WaitW = (MEM_WAIT_MAX > 2) ? $clog2(MEM_WAIT_MAX) : 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_WAIT_MAX - 1);

`ifdef MIPS_MC_JAL_EN
  localparam logic JalEn = 1'b1;
`else
  localparam logic JalEn = 1'b0;
`endif

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpLui   = 6'b001111;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] FnAddu  = 6'b100001;
  localparam logic [5:0] FnSubu  = 6'b100011;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StHalt
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       pc_inst_q, pc_inst_d;
  logic [31:0]       ir_q, ir_d;
  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic [31:0]       alu_q, alu_d;
  logic [31:0]       mdr_q, mdr_d;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic [31:0]       rf_q [32];

  logic              rf_we;
  logic [4:0]        rf_waddr;
  logic [31:0]       rf_wdata;

  // Instruction fields
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [25:0] target;
  logic [31:0] imm_sext, imm_zext, jump_pc;
  logic        insn_legal;

  assign opcode   = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign funct    = ir_q[5:0];
  assign imm      = ir_q[15:0];
  assign target   = ir_q[25:0];
  assign imm_sext = {{16{imm[15]}}, imm};
  assign imm_zext = {16'h0000, imm};
  // pc_q already holds PC+4 once past FETCH.
  assign jump_pc  = {pc_q[31:28], target, 2'b00};

  always_comb begin
    insn_legal = 1'b0;
    case (opcode)
      OpRtype:                           insn_legal = (funct == FnAddu) || (funct == FnSubu);
      OpOri, OpLui, OpLw, OpSw, OpBeq, OpJ: insn_legal = 1'b1;
      OpJal:                             insn_legal = JalEn;
      default:                           insn_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pc_inst_d = pc_inst_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    alu_d     = alu_q;
    mdr_d     = mdr_q;
    wait_d    = '0;
    rf_we     = 1'b0;
    rf_waddr  = 5'd0;
    rf_wdata  = 32'h0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 32'h0;
    retire    = 1'b0;

    unique case (state_q)
      StFetch: begin
        mem_req  = 1'b1;
        mem_addr = pc_q[MEM_AW+1:2];
        if (mem_ready) begin
          ir_d      = mem_rdata;
          pc_inst_d = pc_q;
          pc_d      = pc_q + 32'd4;
          state_d   = StDecode;
        end else if (wait_q == WaitLast) begin
          pc_inst_d = pc_q;
          state_d   = StHalt;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end

      StDecode: begin
        a_d     = rf_q[rs];
        b_d     = rf_q[rt];
        state_d = insn_legal ? StExec : StHalt;
      end

      StExec: begin
        case (opcode)
          OpRtype: begin
            alu_d   = (funct == FnSubu) ? (a_q - b_q) : (a_q + b_q);
            state_d = StWb;
          end
          OpOri: begin
            alu_d   = a_q | imm_zext;
            state_d = StWb;
          end
          OpLui: begin
            alu_d   = {imm, 16'h0000};
            state_d = StWb;
          end
          OpLw, OpSw: begin
            alu_d   = a_q + imm_sext;
            state_d = StMem;
          end
          OpBeq: begin
            if (a_q == b_q) pc_d = pc_q + {imm_sext[29:0], 2'b00};
            retire  = 1'b1;
            state_d = StFetch;
          end
          OpJ: begin
            pc_d    = jump_pc;
            retire  = 1'b1;
            state_d = StFetch;
          end
          OpJal: begin
            rf_we    = 1'b1;
            rf_waddr = 5'd31;
            rf_wdata = pc_q;
            pc_d     = jump_pc;
            retire   = 1'b1;
            state_d  = StFetch;
          end
          default: state_d = StHalt;
        endcase
      end

      StMem: begin
        mem_req  = 1'b1;
        mem_addr = alu_q[MEM_AW+1:2];
        if (opcode == OpSw) begin
          mem_we    = 1'b1;
          mem_wdata = b_q;
        end
        if (mem_ready) begin
          if (opcode == OpSw) begin
            retire  = 1'b1;
            state_d = StFetch;
          end else begin
            mdr_d   = mem_rdata;
            state_d = StWb;
          end
        end else if (wait_q == WaitLast) begin
          state_d = StHalt;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end

      StWb: begin
        rf_we    = 1'b1;
        rf_waddr = (opcode == OpRtype) ? rd : rt;
        rf_wdata = (opcode == OpLw) ? mdr_q : alu_q;
        retire   = 1'b1;
        state_d  = StFetch;
      end

      StHalt: state_d = StHalt;

      default: state_d = StHalt;
    endcase

    // State sits in FETCH while reset is held; keep the bus quiet.
    if (reset) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = 32'h0;
      retire    = 1'b0;
    end
  end

  assign halted = (state_q == StHalt);
  assign pc_out = (state_q == StFetch) ? pc_q : pc_inst_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StFetch;
      pc_q      <= RESET_PC;
      pc_inst_q <= RESET_PC;
      ir_q      <= 32'h0;
      a_q       <= 32'h0;
      b_q       <= 32'h0;
      alu_q     <= 32'h0;
      mdr_q     <= 32'h0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pc_inst_q <= pc_inst_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      alu_q     <= alu_d;
      mdr_q     <= mdr_d;
      wait_q    <= wait_d;
    end
  end

  // R0 is never written, so it always reads zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'h0;
    end else if (rf_we && (rf_waddr != 5'd0)) begin
      rf_q[rf_waddr] <= rf_wdata;
    end
  end

endmodule
